// File: rtl/mips_bus_lsu.sv
// Load/store unit that owns the Avalon master port: lane steering, endian swap, load extension.
// Optional waitrequest timeout abort is enabled with `define MIPS_BUS_LSU_TIMEOUT_EN.
module mips_bus_lsu #(
   parameter int ADDR_W     = 32,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              sign_ext_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              done_o,
   output logic              err_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   input  logic              waitrequest,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic [31:0]       readdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            r_state, w_next;
   logic              r_we, r_sext, r_err;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wbus, r_rdata;
   logic [3:0]        r_be;

   logic              w_misalign, w_accept, w_complete, w_timeout;
   logic [31:0]       w_wbus, w_shift, w_load;
   logic [3:0]        w_be;
   logic [15:0]       w_half;

   assign w_misalign = (size_i == 2'd3) ||
                       (size_i == 2'd1 && addr_i[0]) ||
                       (size_i == 2'd2 && addr_i[1:0] != 2'b00);
   assign w_accept   = (r_state == IDLE) && req_i;
   assign w_complete = (r_state == ACCESS) && !waitrequest;

`ifdef MIPS_BUS_LSU_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] r_cnt;

   // Counts stalled ACCESS cycles; abort on the edge where the count reaches TIMEOUT.
   always_ff @(posedge clk) begin
      if (!reset_i)
         r_cnt <= '0;
      else if (r_state != ACCESS)
         r_cnt <= '0;
      else if (waitrequest)
         r_cnt <= r_cnt + 16'd1;
   end

   assign w_timeout = (r_state == ACCESS) && waitrequest && (r_cnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_i)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_i) w_next = w_misalign ? DONE : ACCESS;
         ACCESS:  if (!waitrequest || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Store lane steering: byte replicated to all lanes, halfword to both halves.
   always_comb begin
      w_wbus = '0;
      w_be   = 4'b0000;
      case (size_i)
         2'd0: begin
            w_wbus = {4{wdata_i[7:0]}};
            w_be   = 4'b0001 << addr_i[1:0];
         end
         2'd1: begin
            w_wbus = BIG_ENDIAN ? {2{wdata_i[7:0], wdata_i[15:8]}} : {2{wdata_i[15:0]}};
            w_be   = 4'b0011 << addr_i[1:0];
         end
         2'd2: begin
            w_wbus = BIG_ENDIAN ? {wdata_i[7:0], wdata_i[15:8], wdata_i[23:16], wdata_i[31:24]}
                                : wdata_i;
            w_be   = 4'b1111;
         end
         default: begin
            w_wbus = '0;
            w_be   = 4'b0000;
         end
      endcase
   end

   // Load path: shift the addressed lane down to bit 0, then swap and extend.
   assign w_shift = readdata >> {r_addr[1:0], 3'b000};
   assign w_half  = BIG_ENDIAN ? {w_shift[7:0], w_shift[15:8]} : w_shift[15:0];

   always_comb begin
      w_load = '0;
      case (r_size)
         2'd0:    w_load = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
         2'd1:    w_load = {{16{r_sext & w_half[15]}}, w_half};
         default: w_load = BIG_ENDIAN ? {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}
                                      : readdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_i) begin
         r_we    <= 1'b0;
         r_sext  <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wbus  <= '0;
         r_be    <= 4'b0000;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_we   <= we_i;
            r_sext <= sign_ext_i;
            r_size <= size_i;
            r_addr <= addr_i;
            r_wbus <= w_misalign ? 32'h0 : w_wbus;
            r_be   <= w_misalign ? 4'b0000 : w_be;
            r_err  <= w_misalign;
         end else if (w_timeout) begin
            r_err  <= 1'b1;
         end
         if (w_complete && !r_we)
            r_rdata <= w_load;
      end
   end

   assign read       = (r_state == ACCESS) && !r_we;
   assign write      = (r_state == ACCESS) && r_we;
   assign done_o     = (r_state == DONE);
   assign err_o      = (r_state == DONE) && r_err;
   assign busy_o     = (r_state != IDLE);
   assign address    = {r_addr[ADDR_W-1:2], 2'b00};
   assign byteenable = r_be;
   assign writedata  = r_wbus;
   assign rdata_o    = r_rdata;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed self-checking bench for mips_bus_lsu (BIG_ENDIAN = 1).
// Define MIPS_BUS_LSU_TIMEOUT_EN to exercise the timeout abort with TIMEOUT = 4.
module tb_mips_bus_lsu;

`ifdef MIPS_BUS_LSU_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic        clk = 1'b0;
   logic        reset_i;
   logic        req_i, we_i, sign_ext_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        done_o, err_o, busy_o;
   logic [31:0] address;
   logic        read, write, waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   mips_bus_lsu #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .address(address), .read(read),
      .write(write), .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp)
         nPass++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one edge, then drops the strobe.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_i      = 1'b1;
      we_i       = we;
      size_i     = size;
      sign_ext_i = sext;
      addr_i     = addr;
      wdata_i    = wdata;
      tick();
      req_i      = 1'b0;
   endtask

   initial begin
      int readCycles;
      logic sawDone;

      reset_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sign_ext_i = 1'b0;
      addr_i = '0; wdata_i = '0; waitrequest = 1'b0; readdata = '0;
      tick(); tick();
      checkOutput("rstRead",  read,       0);
      checkOutput("rstWrite", write,      0);
      checkOutput("rstDone",  done_o,     0);
      checkOutput("rstErr",   err_o,      0);
      checkOutput("rstBusy",  busy_o,     0);
      checkOutput("rstAddr",  address,    0);
      checkOutput("rstBe",    byteenable, 0);
      checkOutput("rstWdata", writedata,  0);
      checkOutput("rstRdata", rdata_o,    0);
      reset_i = 1'b1;
      tick();

      // Word load, big-endian swap, no wait states.
      readdata = 32'h78563412;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      checkOutput("lw.read", read, 1);
      checkOutput("lw.addr", address, 32'h100);
      checkOutput("lw.be",   byteenable, 4'hF);
      checkOutput("lw.busy", busy_o, 1);
      checkOutput("lw.doneEarly", done_o, 0);
      tick();
      checkOutput("lw.done",  done_o, 1);
      checkOutput("lw.err",   err_o, 0);
      checkOutput("lw.readOff", read, 0);
      checkOutput("lw.rdata", rdata_o, 32'h12345678);
      tick();
      checkOutput("lw.idleBusy", busy_o, 0);
      checkOutput("lw.idleDone", done_o, 0);

      // Signed byte load from lane 3 with three wait states; a stray store request is ignored.
      waitrequest = 1'b1;
      readdata    = 32'h80FFFFFF;
      applyStimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h900; size_i = 2'd2;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("lb.read%0d", i), read, 1);
         checkOutput($sformatf("lb.write%0d", i), write, 0);
         checkOutput($sformatf("lb.addr%0d", i), address, 32'h100);
         checkOutput($sformatf("lb.be%0d", i), byteenable, 4'b1000);
         tick();
      end
      req_i = 1'b0;
      waitrequest = 1'b0;
      checkOutput("lb.readLast", read, 1);
      tick();
      checkOutput("lb.done",  done_o, 1);
      checkOutput("lb.rdata", rdata_o, 32'hFFFFFF80);
      tick();
      checkOutput("lb.noRequeue", busy_o, 0);

      // Halfword store to upper half.
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h202, 32'hDEADBEEF);
      checkOutput("sh.write", write, 1);
      checkOutput("sh.read",  read, 0);
      checkOutput("sh.addr",  address, 32'h200);
      checkOutput("sh.be",    byteenable, 4'b1100);
      checkOutput("sh.wdata", writedata, 32'hEFBEEFBE);
      tick();
      checkOutput("sh.done",  done_o, 1);
      checkOutput("sh.err",   err_o, 0);
      checkOutput("sh.rdataKept", rdata_o, 32'hFFFFFF80);
      tick();

      // Byte store replicates into every lane.
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h301, 32'h12345678);
      checkOutput("sb.be",    byteenable, 4'b0010);
      checkOutput("sb.wdata", writedata, 32'h78787878);
      tick(); tick();

      // Word store byte-swapped.
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h304, 32'h11223344);
      checkOutput("sw.wdata", writedata, 32'h44332211);
      checkOutput("sw.be",    byteenable, 4'hF);
      tick(); tick();

      // Signed halfword load at lane 0 and unsigned at lane 2.
      readdata = 32'h000000C3;
      applyStimulus(1'b0, 2'd1, 1'b1, 32'h400, 32'h0);
      checkOutput("lh0.be", byteenable, 4'b0011);
      tick();
      checkOutput("lh0.rdata", rdata_o, 32'hFFFFC300);
      tick();
      readdata = 32'hA55A1234;
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h402, 32'h0);
      tick();
      checkOutput("lhu2.rdata", rdata_o, 32'h00005AA5);
      tick();

      // Misaligned word and reserved size go straight to an error completion.
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
      checkOutput("mis.read", read, 0);
      checkOutput("mis.done", done_o, 1);
      checkOutput("mis.err",  err_o, 1);
      checkOutput("mis.rdataKept", rdata_o, 32'h00005AA5);
      tick();
      checkOutput("mis.errClear", err_o, 0);
      applyStimulus(1'b1, 2'd3, 1'b0, 32'h100, 32'h0);
      checkOutput("rsv.write", write, 0);
      checkOutput("rsv.done",  done_o, 1);
      checkOutput("rsv.err",   err_o, 1);
      tick();

      // Reset in the middle of a stalled access.
      waitrequest = 1'b1;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
      checkOutput("rmid.read", read, 1);
      reset_i = 1'b0;
      tick();
      checkOutput("rmid.readOff", read, 0);
      checkOutput("rmid.busy",    busy_o, 0);
      checkOutput("rmid.done",    done_o, 0);
      reset_i = 1'b1;
      waitrequest = 1'b0;
      tick();
      checkOutput("rmid.noDone", done_o, 0);
      readdata = 32'hAABBCCDD;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
      checkOutput("rmid.newAddr", address, 32'h600);
      tick();
      checkOutput("rmid.newDone",  done_o, 1);
      checkOutput("rmid.newRdata", rdata_o, 32'hDDCCBBAA);
      tick();

      // Waitrequest stuck high.
      waitrequest = 1'b1;
      readdata    = 32'h0;
      readCycles  = 0;
      sawDone     = 1'b0;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h700, 32'h0);
`ifdef MIPS_BUS_LSU_TIMEOUT_EN
      for (int i = 0; i < 20 && !sawDone; i++) begin
         if (read) readCycles++;
         if (done_o) begin
            sawDone = 1'b1;
            checkOutput("to.err", err_o, 1);
            checkOutput("to.rdataKept", rdata_o, 32'hDDCCBBAA);
         end else begin
            tick();
         end
      end
      checkOutput("to.sawDone",    sawDone, 1);
      checkOutput("to.readCycles", readCycles, 4);
`else
      for (int i = 0; i < 100; i++) begin
         if (read) readCycles++;
         if (done_o) sawDone = 1'b1;
         tick();
      end
      checkOutput("stuck.readCycles", readCycles, 100);
      checkOutput("stuck.noDone",     sawDone, 0);
      checkOutput("stuck.stillRead",  read, 1);
`endif
      reset_i = 1'b0;
      waitrequest = 1'b0;
      tick();
      reset_i = 1'b1;
      tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
